vga_fetch_engine: RTL and testbench
===================================

// Module: vga_fetch_engine
// PURPOSE
//  Parametrised framebuffer fetch master for the VGA path; bus master side mirrors the per-word VGA bus handshake.
//  Streams a frame's words from BASE_ADDR up into a prefetch FIFO, ahead of the pixel pipeline.
//  Pixel side pops one word per WORDS_PER_POP request; frame_start (vsync) rewinds the fetch address and flushes the FIFO.
//  Sits between the system bus arbiter and the VGA pixel serialiser.
// PARAMETERS
//  DATA_W      16            bus data width captured per transaction
//  BASE_ADDR   32'h00001050  word address of framebuffer word 0
//  FRAME_WORDS 9600          words per frame (80x240 cells / 2 cells per word)
//  FIFO_DEPTH  8             prefetch entries; power of two, >= 2
//  LVL_W       4             fill-level width, = log2(FIFO_DEPTH)+1
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high
//  frame_start  in   1       one-cycle vsync pulse: rewind + flush
//  bus_ack      in   1       arbiter grant
//  bus_wait     in   1       slave stall while high
//  bus_in       in   DATA_W  read data from slave
//  bus_req      out  1       bus request
//  bus_out      out  32      fetch word address
//  pix_pop      in   1       pixel side consumes head word
//  pix_word     out  DATA_W  FIFO head (first-word-fall-through)
//  pix_valid    out  1       FIFO not empty
//  fill_level   out  LVL_W   entries held + in flight
//  underflow    out  1       one-cycle pulse: pop while empty
// BEHAVIOUR
//  Reset: state IDLE; fetch_idx=0; FIFO empty; bus_req=0, pix_valid=0, underflow=0, fill_level=0; bus_out=BASE_ADDR.
//  bus_out = BASE_ADDR + fetch_idx, 32-bit add, registered; fetch_idx in 0..FRAME_WORDS-1.
//  need = (held + inflight < FIFO_DEPTH) && !frame_done.
//  FSM:
//   IDLE:   bus_req=need; if need && bus_ack -> ADDR.
//   ADDR:   bus_req=1; reserve slot (inflight=1) -> WAIT.
//   WAIT:   bus_req=1; bus_wait ? WAIT : READ.
//   READ:   bus_req=1; bus_in captured on edge ending READ and pushed (unless discard); fetch_idx++ -> FINISH.
//   FINISH: bus_req=0; inflight=0 -> IDLE.
//  Min 4 cycles per word after grant; bus_req guaranteed low >= 1 cycle between words.
//  fetch_idx reaching FRAME_WORDS sets frame_done; no further requests until frame_start.
//  Push never overflows (slot reserved in ADDR); push+pop same cycle when full legal, level unchanged.
//  pix_pop while empty: no state change, pix_word holds last value, underflow=1 next cycle.
//  frame_start in IDLE: FIFO flushed, fetch_idx=0, frame_done=0 same edge.
//  frame_start mid-transaction (ADDR/WAIT/READ): transaction runs to FINISH (bus never aborted), its data discarded;
//   FIFO flushed and fetch_idx=0 on the frame_start edge; FINISH clears discard.
//  frame_start and pix_pop same cycle: flush wins, no underflow.
//  reset mid-transaction: immediate return to reset values; bus_req drops next edge.
//  fill_level = held + inflight; pix_valid = held != 0.
// CONFIGURATION
//  VGA_FETCH_STATS_EN defined: adds output underflow_cnt [15:0], saturating count of underflow pulses,
//   cleared by reset only (not by frame_start).
//  Undefined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  1 reset, bus_ack=1, bus_wait=0 -> bus_out 0x1050,0x1051..; FIFO fills to 8, bus_req low, fill_level=8.
//  2 bus_wait high 5 cycles in first WAIT -> READ entered cycle after bus_wait low; word pushed once, count 1.
//  3 pop 3 with FIFO full -> 3 new fetches issued; pix_word sequence = bus_in order, no loss/dup.
//  4 FRAME_WORDS=4, no pops beyond fill -> exactly 4 transactions, then bus_req=0 until frame_start.
//  5 frame_start during WAIT -> that word dropped, pix_valid=0, next bus_out=0x1050.
//  6 pix_pop when empty -> underflow pulse 1 cycle; with VGA_FETCH_STATS_EN, underflow_cnt 0->1.

Source files
------------

// File: rtl/vga_fetch_engine.sv
// ---------------------------------------------------------------------------
// vga_fetch_engine
//
// Framebuffer fetch master for the VGA path. Walks a frame's words upward from
// BASE_ADDR, one bus transaction at a time. Each returned word is pushed into a
// small first-word-fall-through prefetch FIFO. The pixel serialiser drains that
// FIFO. A vsync pulse (frame_start) rewinds the walk and flushes the FIFO.
//
// Optional feature macro: VGA_FETCH_STATS_EN
//   When it is defined, the module adds the output underflow_cnt[15:0]. This
//   is a saturating count of underflow pulses. Only reset clears it.
//
// Ports
//   clk           in   1       system clock
//   reset         in   1       synchronous, active-high
//   frame_start   in   1       one-cycle vsync pulse: rewind + flush
//   bus_ack       in   1       arbiter grant
//   bus_wait      in   1       slave stall while high
//   bus_in        in   DATA_W  read data from slave
//   bus_req       out  1       bus request
//   bus_out       out  32      fetch word address (registered)
//   pix_pop       in   1       pixel side consumes head word
//   pix_word      out  DATA_W  FIFO head, holds last value when empty
//   pix_valid     out  1       FIFO not empty
//   fill_level    out  LVL_W   entries held + transaction in flight
//   underflow     out  1       one-cycle pulse after a pop while empty
//   underflow_cnt out  16      (VGA_FETCH_STATS_EN only)
// ---------------------------------------------------------------------------
module vga_fetch_engine #(
    parameter int          DATA_W      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h00001050,
    parameter int          FRAME_WORDS = 9600,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          LVL_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              bus_ack,
    input  logic              bus_wait,
    input  logic [DATA_W-1:0] bus_in,
    output logic              bus_req,
    output logic [31:0]       bus_out,
    input  logic              pix_pop,
    output logic [DATA_W-1:0] pix_word,
    output logic              pix_valid,
    output logic [LVL_W-1:0]  fill_level,
    output logic              underflow
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(FRAME_WORDS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]        state;
    logic              run;         // low for the first cycle after reset so bus_req comes up registered
    logic              inflight;    // slot reserved for the current transaction
    logic              discard;     // current transaction straddled a frame_start
    logic              frame_done;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  idx_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  held;

    logic [LVL_W:0]    occupancy;
    logic              need;
    logic              push;
    logic              pop;
    logic              pop_empty;
    logic              last_word;
    logic              mid_txn;

    // Occupancy counts the reserved slot. This keeps a push from overflowing.
    assign occupancy = {1'b0, held} + (LVL_W+1)'(inflight);
    assign need      = (occupancy < (LVL_W+1)'(FIFO_DEPTH)) && !frame_done;
    assign mid_txn   = (state == S_ADDR) || (state == S_WAIT) || (state == S_READ);
    // A flush on this edge also drops the word being read on this edge.
    assign push      = (state == S_READ) && !discard && !frame_start;
    assign pop       = pix_pop && (held != '0) && !frame_start;
    assign pop_empty = pix_pop && (held == '0) && !frame_start;
    assign last_word = fetch_idx == IDX_W'(FRAME_WORDS - 1);

    assign pix_valid  = held != '0;
    assign fill_level = occupancy[LVL_W-1:0];

    always_comb begin
        case (state)
            S_IDLE:   bus_req = run && need;
            S_FINISH: bus_req = 1'b0;
            default:  bus_req = 1'b1;
        endcase
    end

    // The index advances only on a word that is kept. At the end of a frame
    // it wraps to 0. frame_done then blocks further requests.
    always_comb begin
        idx_next = fetch_idx;
        if (frame_start)
            idx_next = '0;
        else if (push)
            idx_next = last_word ? '0 : fetch_idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            run        <= 1'b0;
            inflight   <= 1'b0;
            discard    <= 1'b0;
            frame_done <= 1'b0;
            fetch_idx  <= '0;
            bus_out    <= BASE_ADDR;
        end else begin
            run       <= 1'b1;
            fetch_idx <= idx_next;
            bus_out   <= BASE_ADDR + 32'(idx_next);

            if (frame_start)
                frame_done <= 1'b0;
            else if (push && last_word)
                frame_done <= 1'b1;

            // The bus cycle is never aborted. A frame_start only marks the
            // transaction's data for discard.
            if (frame_start && mid_txn)
                discard <= 1'b1;
            else if (state == S_FINISH)
                discard <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (run && need && bus_ack) begin
                        state    <= S_ADDR;
                        inflight <= 1'b1;
                    end
                end
                S_ADDR:   state <= S_WAIT;
                S_WAIT:   if (!bus_wait) state <= S_READ;
                S_READ: begin
                    state    <= S_FINISH;
                    inflight <= 1'b0;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage. There is no reset, because held gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            held      <= '0;
            pix_word  <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= pop_empty;
            if (frame_start) begin
                // The flush drops the contents but leaves pix_word unchanged.
                held   <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                held <= held + LVL_W'(push) - LVL_W'(pop);
                // pix_word is a registered copy of the head. When the FIFO
                // drains, it keeps the last word.
                if (pop && held > LVL_W'(1))
                    pix_word <= mem[rd_ptr + PTR_W'(1)];
                else if (push && (held - LVL_W'(pop)) == '0)
                    pix_word <= bus_in;
            end
        end
    end

`ifdef VGA_FETCH_STATS_EN
    // Counts on the same condition that raises underflow, so both change together.
    always_ff @(posedge clk) begin
        if (reset)
            underflow_cnt <= '0;
        else if (pop_empty && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_fetch_engine.sv
// Directed bench for vga_fetch_engine. Inputs change on the falling edge and
// outputs are sampled there. The slave returns 0xD000 | address[11:0].
// A second instance with FRAME_WORDS=4 covers the end-of-frame stop.
module tb_vga_fetch_engine;

    logic        clk = 1'b0;
    logic        reset, frame_start, bus_ack, bus_wait, pix_pop;
    logic [15:0] bus_in, pix_word;
    logic        bus_req, pix_valid, underflow;
    logic [31:0] bus_out;
    logic [3:0]  fill_level;

    logic        frame_start2;
    logic [15:0] bus_in2, pix_word2;
    logic        bus_req2, pix_valid2, underflow2;
    logic [31:0] bus_out2;
    logic [3:0]  fill_level2;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0] uf_cnt, uf_cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int tx2     = 0;
    logic req2_prev = 1'b0;

    always #5 clk = ~clk;

    assign bus_in  = 16'hD000 | {4'h0, bus_out[11:0]};
    assign bus_in2 = 16'hD000 | {4'h0, bus_out2[11:0]};

    vga_fetch_engine dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .bus_ack(bus_ack), .bus_wait(bus_wait), .bus_in(bus_in),
        .bus_req(bus_req), .bus_out(bus_out), .pix_pop(pix_pop),
        .pix_word(pix_word), .pix_valid(pix_valid),
        .fill_level(fill_level), .underflow(underflow)
`ifdef VGA_FETCH_STATS_EN
        , .underflow_cnt(uf_cnt)
`endif
    );

    vga_fetch_engine #(.FRAME_WORDS(4)) dut2 (
        .clk(clk), .reset(reset), .frame_start(frame_start2),
        .bus_ack(1'b1), .bus_wait(1'b0), .bus_in(bus_in2),
        .bus_req(bus_req2), .bus_out(bus_out2), .pix_pop(1'b0),
        .pix_word(pix_word2), .pix_valid(pix_valid2),
        .fill_level(fill_level2), .underflow(underflow2)
`ifdef VGA_FETCH_STATS_EN
        , .underflow_cnt(uf_cnt2)
`endif
    );

    // Each dut2 transaction shows up as one rising edge of bus_req.
    always @(negedge clk) begin
        if (reset) begin
            tx2       <= 0;
            req2_prev <= 1'b0;
        end else begin
            if (bus_req2 && !req2_prev) tx2 <= tx2 + 1;
            req2_prev <= bus_req2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; bus_ack = 1'b0; bus_wait = 1'b0;
        pix_pop = 1'b0; frame_start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req",   32'(bus_req),    32'h0);
        chk("rst_valid", 32'(pix_valid),  32'h0);
        chk("rst_uf",    32'(underflow),  32'h0);
        chk("rst_fill",  32'(fill_level), 32'h0);
        chk("rst_addr",  bus_out,         32'h1050);
`ifdef VGA_FETCH_STATS_EN
        chk("rst_ufcnt", 32'(uf_cnt),     32'h0);
`endif

        // First transaction stalls in WAIT.
        reset = 1'b0; bus_ack = 1'b1; bus_wait = 1'b1;
        repeat (10) @(negedge clk);
        chk("wait_fill",  32'(fill_level), 32'h1);
        chk("wait_valid", 32'(pix_valid),  32'h0);
        chk("wait_req",   32'(bus_req),    32'h1);
        bus_wait = 1'b0;
        @(negedge clk);
        chk("read_valid", 32'(pix_valid),  32'h0);
        @(negedge clk);
        chk("fin_valid",  32'(pix_valid),  32'h1);
        chk("fin_word",   32'(pix_word),   32'hD050);
        chk("fin_fill",   32'(fill_level), 32'h1);
        chk("fin_req",    32'(bus_req),    32'h0);
        chk("fin_addr",   bus_out,         32'h1051);

        // Fill to depth.
        repeat (60) @(negedge clk);
        chk("full_fill", 32'(fill_level), 32'h8);
        chk("full_req",  32'(bus_req),    32'h0);
        chk("full_addr", bus_out,         32'h1058);
        chk("full_word", 32'(pix_word),   32'hD050);

        // Three pops trigger three refills.
        pix_pop = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("pop3_word", 32'(pix_word), 32'hD050 + 32'(i));
        end
        pix_pop = 1'b0;
        repeat (40) @(negedge clk);
        chk("refill_fill", 32'(fill_level), 32'h8);
        chk("refill_addr", bus_out,         32'h105B);

        // Draining while refills race in keeps the word order.
        for (int i = 0; i < 8; i++) begin
            chk("drain_word", 32'(pix_word), 32'hD053 + 32'(i));
            pix_pop = 1'b1;
            @(negedge clk);
        end
        pix_pop = 1'b0;
        bus_ack = 1'b0;
        repeat (10) @(negedge clk);

        // Flush while idle.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("flush_valid", 32'(pix_valid),  32'h0);
        chk("flush_fill",  32'(fill_level), 32'h0);
        chk("flush_addr",  bus_out,         32'h1050);

        // Flush and pop together: no underflow.
        frame_start = 1'b1; pix_pop = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; pix_pop = 1'b0;
        chk("fs_pop_uf", 32'(underflow), 32'h0);

        // Pop while empty.
        pix_pop = 1'b1;
        @(negedge clk);
        pix_pop = 1'b0;
        chk("uf_pulse", 32'(underflow), 32'h1);
`ifdef VGA_FETCH_STATS_EN
        chk("uf_cnt1", 32'(uf_cnt), 32'h1);
`endif
        @(negedge clk);
        chk("uf_clear", 32'(underflow), 32'h0);

        // frame_start during WAIT drops that word.
        bus_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("fs_pre_word", 32'(pix_word), 32'hD050);
        chk("fs_pre_fill", 32'(fill_level), 32'h1);
        bus_wait = 1'b1;
        repeat (4) @(negedge clk);
        chk("fs_wait_addr", bus_out,         32'h1051);
        chk("fs_wait_fill", 32'(fill_level), 32'h2);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_mid_valid", 32'(pix_valid), 32'h0);
        chk("fs_mid_addr",  bus_out,        32'h1050);
        bus_wait = 1'b0;
        repeat (2) @(negedge clk);
        chk("fs_drop_valid", 32'(pix_valid), 32'h0);
        chk("fs_drop_addr",  bus_out,        32'h1050);
        repeat (6) @(negedge clk);
        chk("fs_next_valid", 32'(pix_valid), 32'h1);
        chk("fs_next_word",  32'(pix_word),  32'hD050);
        chk("fs_next_addr",  bus_out,        32'h1051);

        // Short frame on dut2: exactly four transactions, then silence.
        chk("eof_tx",   32'(tx2),         32'd4);
        chk("eof_req",  32'(bus_req2),    32'h0);
        chk("eof_fill", 32'(fill_level2), 32'h4);
        chk("eof_addr", bus_out2,         32'h1050);
        chk("eof_word", 32'(pix_word2),   32'hD050);
        frame_start2 = 1'b1;
        @(negedge clk);
        frame_start2 = 1'b0;
        chk("eof_restart_req",   32'(bus_req2),    32'h1);
        chk("eof_restart_fill",  32'(fill_level2), 32'h0);
        chk("eof_restart_valid", 32'(pix_valid2),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
